// File: rtl/run_mon_pkg.sv
// Shared types and constants for the run monitor.
// The optional stall counter is enabled with RUN_MON_STALL_EN.
package run_mon_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } t_RunState;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    // Result codes used when printing the outcome of a run
    localparam int unsigned RES_PASS    = 0;
    localparam int unsigned RES_FAIL    = 1;
    localparam int unsigned RES_TIMEOUT = 2;

    function automatic int unsigned result_code(input logic pass, input logic timeout);
        if (timeout)   return RES_TIMEOUT;
        else if (pass) return RES_PASS;
        else           return RES_FAIL;
    endfunction

endpackage

// File: rtl/run_monitor_if.sv
// Memory-tap, retire and result signals between the run monitor and its environment.
// i_Stall / o_StallCount exist only when RUN_MON_STALL_EN is defined.
interface run_monitor_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                  i_MemWrite;
    logic [ADDR_WIDTH-1:0] i_MemAddr;
    logic [DATA_WIDTH-1:0] i_MemWData;
    logic                  i_Retire;
    logic                  o_CoreReset;
    logic                  o_Done;
    logic                  o_Pass;
    logic                  o_Timeout;
    logic [DATA_WIDTH-2:0] o_ExitCode;
    logic [CNT_WIDTH-1:0]  o_CycleCount;
    logic [CNT_WIDTH-1:0]  o_RetireCount;
`ifdef RUN_MON_STALL_EN
    logic                  i_Stall;
    logic [CNT_WIDTH-1:0]  o_StallCount;
`endif

    modport master (
        output i_MemWrite, i_MemAddr, i_MemWData, i_Retire,
`ifdef RUN_MON_STALL_EN
        output i_Stall,
        input  o_StallCount,
`endif
        input  o_CoreReset, o_Done, o_Pass, o_Timeout, o_ExitCode,
        input  o_CycleCount, o_RetireCount
    );

    modport slave (
        input  i_MemWrite, i_MemAddr, i_MemWData, i_Retire,
`ifdef RUN_MON_STALL_EN
        input  i_Stall,
        output o_StallCount,
`endif
        output o_CoreReset, o_Done, o_Pass, o_Timeout, o_ExitCode,
        output o_CycleCount, o_RetireCount
    );
endinterface

// File: rtl/run_monitor_sat_counter.sv
// Up-counter that sticks at all-ones, with enable and synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        count <= '0;
        else if (clr)                   count <= '0;
        else if (en && (count != '1))   count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/run_monitor.sv
// Run-control and completion monitor: holds the core in reset, counts the run,
// and latches pass/fail/timeout. Optional stall counter under RUN_MON_STALL_EN.
module run_monitor
    import run_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned RESET_HOLD = 2,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(TOHOST_ADDR_DEFAULT)
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    run_monitor_if.slave bus
);
    localparam int unsigned HOLD_N    = (RESET_HOLD == 0) ? 1 : RESET_HOLD;
    localparam int unsigned HOLD_W    = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
    localparam int unsigned LIM_W     = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);
    localparam logic [LIM_W-1:0]  LIM_LAST  = LIM_W'(MAX_CYCLES - 1);

    t_RunState             state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [LIM_W-1:0]      lim_cnt;
    logic                  core_reset;
    logic                  done;
    logic                  pass;
    logic                  timeout;
    logic [DATA_WIDTH-2:0] exit_code;
    logic                  complete;
    logic                  in_run;
    logic                  in_hold;

    assign in_run   = (state == RUN);
    assign in_hold  = (state == HOLD);
    assign complete = bus.i_MemWrite && (bus.i_MemAddr == TOHOST_ADDR) && bus.i_MemWData[0];

    // lim_cnt is a private run-cycle count so the timeout is exact even when
    // the visible cycle counter is narrower than MAX_CYCLES and saturates.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= HOLD;
            core_reset <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            exit_code  <= '0;
            hold_cnt   <= '0;
            lim_cnt    <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    lim_cnt <= lim_cnt + LIM_W'(1);
                    if (complete) begin
                        state      <= DONE;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        exit_code  <= bus.i_MemWData[DATA_WIDTH-1:1];
                        pass       <= (bus.i_MemWData[DATA_WIDTH-1:1] == '0);
                    end else if (lim_cnt == LIM_LAST) begin
                        state      <= DONE;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (i_Clk),
        .rst   (i_Reset),
        .clr   (in_hold),
        .en    (in_run),
        .count (bus.o_CycleCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
        .clk   (i_Clk),
        .rst   (i_Reset),
        .clr   (in_hold),
        .en    (in_run && bus.i_Retire),
        .count (bus.o_RetireCount)
    );

`ifdef RUN_MON_STALL_EN
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (i_Clk),
        .rst   (i_Reset),
        .clr   (in_hold),
        .en    (in_run && bus.i_Stall),
        .count (bus.o_StallCount)
    );
`endif

    assign bus.o_CoreReset = core_reset;
    assign bus.o_Done      = done;
    assign bus.o_Pass      = pass;
    assign bus.o_Timeout   = timeout;
    assign bus.o_ExitCode  = exit_code;
endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: hold window, pass, fail, timeout, tie, async reset,
// and saturation on a narrow-counter instance (stall counter when RUN_MON_STALL_EN).
module tb_run_monitor;
    import run_mon_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    run_monitor_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(32)) bus_a ();
    run_monitor_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4))  bus_b ();

    run_monitor #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(32),
        .MAX_CYCLES(100), .RESET_HOLD(2), .TOHOST_ADDR(32'h0000_1000)
    ) u_dut_a (
        .i_Clk   (clk),
        .i_Reset (rst_a),
        .bus     (bus_a)
    );

    run_monitor #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4),
        .MAX_CYCLES(40), .RESET_HOLD(0), .TOHOST_ADDR(32'h0000_1000)
    ) u_dut_b (
        .i_Clk   (clk),
        .i_Reset (rst_b),
        .bus     (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.i_MemWrite = 1'b0;
        bus_a.i_MemAddr  = '0;
        bus_a.i_MemWData = '0;
        bus_a.i_Retire   = 1'b0;
    endtask

    // Reset, release, and walk through the two-edge hold window into RUN
    task automatic reset_a(input string tag);
        rst_a = 1'b1;
        idle_a();
        tick();
        check({tag, "_rst_core"}, 64'(bus_a.o_CoreReset), 64'd1);
        check({tag, "_rst_done"}, 64'(bus_a.o_Done), 64'd0);
        check({tag, "_rst_cyc"},  64'(bus_a.o_CycleCount), 64'd0);
        tick();
        rst_a = 1'b0;
        bus_a.i_Retire = 1'b1;
        tick();
        check({tag, "_hold1_core"}, 64'(bus_a.o_CoreReset), 64'd1);
        check({tag, "_hold1_ret"},  64'(bus_a.o_RetireCount), 64'd0);
        tick();
        bus_a.i_Retire = 1'b0;
        check({tag, "_hold2_core"}, 64'(bus_a.o_CoreReset), 64'd0);
        check({tag, "_hold2_cyc"},  64'(bus_a.o_CycleCount), 64'd0);
        check({tag, "_hold2_ret"},  64'(bus_a.o_RetireCount), 64'd0);
    endtask

    task automatic run_a(input int n, input int nret);
        for (int i = 0; i < n; i++) begin
            bus_a.i_Retire = (i < nret);
            tick();
        end
        bus_a.i_Retire = 1'b0;
    endtask

    task automatic store_a(input logic [31:0] addr, input logic [31:0] data);
        bus_a.i_MemWrite = 1'b1;
        bus_a.i_MemAddr  = addr;
        bus_a.i_MemWData = data;
        tick();
        bus_a.i_MemWrite = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle_a();
        bus_b.i_MemWrite = 1'b0;
        bus_b.i_MemAddr  = '0;
        bus_b.i_MemWData = '0;
        bus_b.i_Retire   = 1'b0;
`ifdef RUN_MON_STALL_EN
        bus_a.i_Stall = 1'b0;
        bus_b.i_Stall = 1'b0;
`endif

        // Pass: 10 retires, completion store on the 20th run cycle
        reset_a("pass");
        run_a(19, 10);
        check("pass_pre_done", 64'(bus_a.o_Done), 64'd0);
        check("pass_pre_cyc",  64'(bus_a.o_CycleCount), 64'd19);
        store_a(32'h0000_1000, 32'h1);
        check("pass_done", 64'(bus_a.o_Done), 64'd1);
        check("pass_pass", 64'(bus_a.o_Pass), 64'd1);
        check("pass_tmo",  64'(bus_a.o_Timeout), 64'd0);
        check("pass_exit", 64'(bus_a.o_ExitCode), 64'd0);
        check("pass_cyc",  64'(bus_a.o_CycleCount), 64'd20);
        check("pass_ret",  64'(bus_a.o_RetireCount), 64'd10);
        check("pass_core", 64'(bus_a.o_CoreReset), 64'd1);
        $display("INFO result code after pass run = %0d", result_code(bus_a.o_Pass, bus_a.o_Timeout));

        // Reset while in DONE clears outputs without waiting for an edge
        #2 rst_a = 1'b1;
        #1;
        check("done_async_done", 64'(bus_a.o_Done), 64'd0);
        check("done_async_pass", 64'(bus_a.o_Pass), 64'd0);
        check("done_async_cyc",  64'(bus_a.o_CycleCount), 64'd0);

        // Fail: even data and wrong address ignored, then exit code 3
        reset_a("fail");
        store_a(32'h0000_1000, 32'h2);
        check("fail_even_ignored", 64'(bus_a.o_Done), 64'd0);
        store_a(32'h0000_1004, 32'h1);
        check("fail_addr_ignored", 64'(bus_a.o_Done), 64'd0);
        store_a(32'h0000_1000, 32'h7);
        check("fail_done", 64'(bus_a.o_Done), 64'd1);
        check("fail_pass", 64'(bus_a.o_Pass), 64'd0);
        check("fail_tmo",  64'(bus_a.o_Timeout), 64'd0);
        check("fail_exit", 64'(bus_a.o_ExitCode), 64'd3);
        check("fail_cyc",  64'(bus_a.o_CycleCount), 64'd3);
        run_a(5, 5);
        store_a(32'h0000_1000, 32'h1);
        check("frozen_exit", 64'(bus_a.o_ExitCode), 64'd3);
        check("frozen_pass", 64'(bus_a.o_Pass), 64'd0);
        check("frozen_cyc",  64'(bus_a.o_CycleCount), 64'd3);
        check("frozen_ret",  64'(bus_a.o_RetireCount), 64'd0);

        // Timeout at MAX_CYCLES with no completion
        reset_a("tmo");
        run_a(99, 0);
        check("tmo_pre_done", 64'(bus_a.o_Done), 64'd0);
        check("tmo_pre_cyc",  64'(bus_a.o_CycleCount), 64'd99);
        tick();
        check("tmo_done", 64'(bus_a.o_Done), 64'd1);
        check("tmo_tmo",  64'(bus_a.o_Timeout), 64'd1);
        check("tmo_pass", 64'(bus_a.o_Pass), 64'd0);
        check("tmo_exit", 64'(bus_a.o_ExitCode), 64'd0);
        check("tmo_cyc",  64'(bus_a.o_CycleCount), 64'd100);
        check("tmo_core", 64'(bus_a.o_CoreReset), 64'd1);
        tick();
        check("tmo_cyc_frozen", 64'(bus_a.o_CycleCount), 64'd100);

        // Completion on the timeout cycle wins
        reset_a("tie");
        run_a(99, 0);
        store_a(32'h0000_1000, 32'h1);
        check("tie_done", 64'(bus_a.o_Done), 64'd1);
        check("tie_pass", 64'(bus_a.o_Pass), 64'd1);
        check("tie_tmo",  64'(bus_a.o_Timeout), 64'd0);
        check("tie_cyc",  64'(bus_a.o_CycleCount), 64'd100);

        // Asynchronous reset in the middle of run cycle 37
        reset_a("mid");
        run_a(36, 36);
        bus_a.i_Retire = 1'b1;
        @(posedge clk);
        #1;
        check("mid_pre_cyc", 64'(bus_a.o_CycleCount), 64'd37);
        check("mid_pre_ret", 64'(bus_a.o_RetireCount), 64'd37);
        #2 rst_a = 1'b1;
        #1;
        check("mid_async_core", 64'(bus_a.o_CoreReset), 64'd1);
        check("mid_async_cyc",  64'(bus_a.o_CycleCount), 64'd0);
        check("mid_async_ret",  64'(bus_a.o_RetireCount), 64'd0);
        tick();
        reset_a("mid_rel");
        run_a(5, 2);
        check("mid_restart_cyc", 64'(bus_a.o_CycleCount), 64'd5);
        check("mid_restart_ret", 64'(bus_a.o_RetireCount), 64'd2);

        // Narrow counters saturate; internal limit still times out at 40; hold of 0 acts as 1
        tick();
        check("sat_rst_core", 64'(bus_b.o_CoreReset), 64'd1);
        rst_b = 1'b0;
        bus_b.i_Retire = 1'b1;
`ifdef RUN_MON_STALL_EN
        bus_b.i_Stall = 1'b1;
`endif
        tick();
        check("sat_hold_core", 64'(bus_b.o_CoreReset), 64'd0);
        check("sat_hold_cyc",  64'(bus_b.o_CycleCount), 64'd0);
        for (int i = 0; i < 39; i++) tick();
        check("sat_pre_done", 64'(bus_b.o_Done), 64'd0);
        check("sat_cyc",      64'(bus_b.o_CycleCount), 64'd15);
        check("sat_ret",      64'(bus_b.o_RetireCount), 64'd15);
`ifdef RUN_MON_STALL_EN
        check("sat_stall",    64'(bus_b.o_StallCount), 64'd15);
`endif
        tick();
        check("sat_done",     64'(bus_b.o_Done), 64'd1);
        check("sat_tmo",      64'(bus_b.o_Timeout), 64'd1);
        check("sat_cyc_done", 64'(bus_b.o_CycleCount), 64'd15);
        check("sat_core",     64'(bus_b.o_CoreReset), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
